// File: rtl/switch_debouncer_pkg.sv
// Shared constants and types for the switch debouncer: display clock rate,
// default debounce window and the per-bit filter state encoding.
package switch_debouncer_pkg;

  localparam int CLK_DISP_HZ             = 10_000_000;
  localparam int DEBOUNCE_MS_DEFAULT     = 10;
  localparam int NUM_SWITCHES            = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_DISP_HZ / 1000) * DEBOUNCE_MS_DEFAULT;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } db_state_t;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch bundle between the board pins and the debouncer: raw levels in,
// debounced levels and edge pulses out. Unidirectional, no backpressure.
interface switch_debouncer_if
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH = NUM_SWITCHES
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  modport master (
    output sw_raw,
    input  sw_stable,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );

  modport slave (
    input  sw_raw,
    output sw_stable,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );

endinterface

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: 2-FF synchroniser, persistence counter, stable level and rise/fall pulses.
// Latency: DEBOUNCE_CYCLES+2 edges from raw change to stable update; no backpressure.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic rise_term,
  output logic fall_term
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      state  <= ST_IDLE;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      stable <= stable_nxt;
      rise   <= rise_term;
      fall   <= fall_term;
    end
  end

  // The counter stops at CNT_LAST: that is where the transition resolves, so it never wraps.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stable_nxt = stable;
    rise_term  = 1'b0;
    fall_term  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (s2 != stable) begin
          state_nxt = ST_COUNT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_COUNT: begin
        if (s2 == stable) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = ST_IDLE;
          cnt_nxt    = '0;
          stable_nxt = s2;
          rise_term  = s2;
          fall_term  = ~s2;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw slide switches into stable levels plus aligned rise/fall/changed pulses.
// Latency: DEBOUNCE_CYCLES+2 clk edges per transition; outputs are never stalled.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = NUM_SWITCHES,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  switch_debouncer_if.slave sw
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rise_term;
  logic [WIDTH-1:0] fall_term;
  logic             changed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .raw       (sw.sw_raw[i]),
      .stable    (stable[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .rise_term (rise_term[i]),
      .fall_term (fall_term[i])
    );
  end

  // Built from the unregistered terms so it lands on the same edge as the per-bit pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      changed <= 1'b0;
    end else begin
      changed <= |(rise_term | fall_term);
    end
  end

  assign sw.sw_stable  = stable;
  assign sw.sw_rise    = rise;
  assign sw.sw_fall    = fall;
  assign sw.sw_changed = changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES = 8 (transition lands on edge 10).
module tb_switch_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  int rise_cnt [4] = '{default: 0};
  int fall_cnt [4] = '{default: 0};
  int chg_cnt      = 0;
  int overlap_cnt  = 0;
  int r0 [4];
  int f0 [4];
  int c0;

  switch_debouncer_if #(.WIDTH(4)) sw_if ();

  switch_debouncer #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (sw_if.sw_rise[b] === 1'b1) rise_cnt[b]++;
      if (sw_if.sw_fall[b] === 1'b1) fall_cnt[b]++;
    end
    if (sw_if.sw_changed === 1'b1) chg_cnt++;
    if ((sw_if.sw_rise & sw_if.sw_fall) !== 4'b0000) overlap_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic snap();
    for (int b = 0; b < 4; b++) begin
      r0[b] = rise_cnt[b];
      f0[b] = fall_cnt[b];
    end
    c0 = chg_cnt;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rise"}, sw_if.sw_rise, 4'b0000);
    chk({tag, "_fall"}, sw_if.sw_fall, 4'b0000);
    chk({tag, "_chg"}, 4'(sw_if.sw_changed), 4'd0);
  endtask

  initial begin
    // 1. reset with switches low
    sw_if.sw_raw = 4'b0000;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("rst_stable", sw_if.sw_stable, 4'b0000);
      chk_quiet("rst");
    end
    rst = 1'b0;
    step(1);
    chk("post_rst_stable", sw_if.sw_stable, 4'b0000);
    chk_quiet("post_rst");

    // 2. single bit rises and is held
    snap();
    sw_if.sw_raw = 4'b0001;
    step(9);
    chk("t2_edge9_stable", sw_if.sw_stable, 4'b0000);
    step(1);
    chk("t2_edge10_stable", sw_if.sw_stable, 4'b0001);
    chk("t2_edge10_rise", sw_if.sw_rise, 4'b0001);
    chk("t2_edge10_fall", sw_if.sw_fall, 4'b0000);
    chk("t2_edge10_chg", 4'(sw_if.sw_changed), 4'd1);
    step(1);
    chk("t2_edge11_stable", sw_if.sw_stable, 4'b0001);
    chk_quiet("t2_edge11");
    chk("t2_rise_count", 4'(rise_cnt[0] - r0[0]), 4'd1);
    chk("t2_chg_count", 4'(chg_cnt - c0), 4'd1);

    // 3. short glitch on bit 2 is filtered
    snap();
    sw_if.sw_raw = 4'b0101;
    step(5);
    sw_if.sw_raw = 4'b0001;
    step(20);
    chk("t3_stable", sw_if.sw_stable, 4'b0001);
    chk("t3_rise_count", 4'(rise_cnt[2] - r0[2]), 4'd0);
    chk("t3_chg_count", 4'(chg_cnt - c0), 4'd0);

    // 4. bit 1 bounces every 3 cycles, then settles high
    snap();
    for (int t = 0; t < 6; t++) begin
      sw_if.sw_raw[1] = ~sw_if.sw_raw[1];
      step(3);
    end
    chk("t4_bounce_stable", sw_if.sw_stable, 4'b0001);
    sw_if.sw_raw[1] = 1'b1;
    step(9);
    chk("t4_edge9_stable", sw_if.sw_stable, 4'b0001);
    step(1);
    chk("t4_edge10_stable", sw_if.sw_stable, 4'b0011);
    chk("t4_edge10_rise", sw_if.sw_rise, 4'b0010);
    step(2);
    chk("t4_rise_count", 4'(rise_cnt[1] - r0[1]), 4'd1);
    chk("t4_fall_count", 4'(fall_cnt[1] - f0[1]), 4'd0);
    chk("t4_chg_count", 4'(chg_cnt - c0), 4'd1);

    // 5. two bits fall while two others rise on the same cycle
    snap();
    sw_if.sw_raw = 4'b1100;
    step(9);
    chk("t5_edge9_stable", sw_if.sw_stable, 4'b0011);
    step(1);
    chk("t5_edge10_stable", sw_if.sw_stable, 4'b1100);
    chk("t5_edge10_rise", sw_if.sw_rise, 4'b1100);
    chk("t5_edge10_fall", sw_if.sw_fall, 4'b0011);
    chk("t5_edge10_chg", 4'(sw_if.sw_changed), 4'd1);
    step(1);
    chk_quiet("t5_edge11");
    chk("t5_chg_count", 4'(chg_cnt - c0), 4'd1);

    // 6. reset in the middle of a count on bit 3
    sw_if.sw_raw = 4'b0000;
    step(12);
    chk("t6_pre_stable", sw_if.sw_stable, 4'b0000);
    snap();
    sw_if.sw_raw = 4'b1000;
    step(7);
    chk("t6_counting_stable", sw_if.sw_stable, 4'b0000);
    rst = 1'b1;
    step(1);
    chk("t6_rst_stable", sw_if.sw_stable, 4'b0000);
    chk_quiet("t6_rst_a");
    step(1);
    chk_quiet("t6_rst_b");
    rst = 1'b0;
    step(9);
    chk("t6_edge9_stable", sw_if.sw_stable, 4'b0000);
    chk("t6_rise_during", 4'(rise_cnt[3] - r0[3]), 4'd0);
    step(1);
    chk("t6_edge10_stable", sw_if.sw_stable, 4'b1000);
    chk("t6_edge10_rise", sw_if.sw_rise, 4'b1000);
    chk("t6_edge10_chg", 4'(sw_if.sw_changed), 4'd1);
    step(2);
    chk("t6_rise_count", 4'(rise_cnt[3] - r0[3]), 4'd1);

    chk("rise_fall_overlap", 4'(overlap_cnt), 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
